instruction_fetcher: RTL and testbench

- Per-core fetch stage that sits directly upstream of the instruction decoder.
- When the core's SIMD state machine enters FETCH, it reads the instruction at the current PC from program memory over a valid/ready handshake.
- It holds the instruction word stable for the decoder and reports fetch completion back to the core scheduler.
- A single-entry last-fetch buffer skips the memory access when the same PC is fetched again, for example on loop re-entry or a stalled warp.

---
 rtl/instruction_fetcher_if.sv | 25 ++
 rtl/instruction_fetcher.sv | 109 ++++++++++
 tb/tb_instruction_fetcher.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel between a fetch stage and its memory.
// The fetcher drives the request; memory answers with ready and data.
interface instruction_fetcher_if #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int INSTRUCTION_WIDTH     = 32
);
    logic                             mem_read_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address;
    logic                             mem_read_ready;
    logic [INSTRUCTION_WIDTH-1:0]     mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Per-core fetch stage with a single-entry last-fetch buffer
// that skips program memory when the same PC is fetched again.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int INSTRUCTION_WIDTH     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [2:0]                       simd_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
    input  logic                             invalidate,
    instruction_fetcher_if.master            mem,
    output logic [2:0]                       fetcher_state,
    output logic [INSTRUCTION_WIDTH-1:0]     instruction,
    output logic [15:0]                      miss_count
);
    localparam logic [2:0] SIMD_FETCH  = 3'd1;
    localparam logic [2:0] SIMD_DECODE = 3'd2;

    typedef enum logic [2:0] {
        F_IDLE       = 3'd0,
        F_REQUESTING = 3'd1,
        F_FETCHED    = 3'd2
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    logic                             buf_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_addr;
    logic [INSTRUCTION_WIDTH-1:0]     buf_data;

    logic hit;
    logic start;
    logic done;

    // A same-cycle invalidate must not let a stale entry satisfy the fetch.
    assign hit = buf_valid && (pc == buf_addr) && !invalidate;
    assign fetcher_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= F_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (enable && simd_state == SIMD_FETCH) begin
                    start      = 1'b1;
                    state_next = hit ? F_FETCHED : F_REQUESTING;
                end
            end
            F_REQUESTING: begin
                if (mem.mem_read_ready) begin
                    done       = 1'b1;
                    state_next = F_FETCHED;
                end
            end
            F_FETCHED: begin
                if (simd_state == SIMD_DECODE) begin
                    state_next = F_IDLE;
                end
            end
            default: state_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.mem_read_valid   <= 1'b0;
            mem.mem_read_address <= '0;
            instruction          <= '0;
            miss_count           <= '0;
            buf_valid            <= 1'b0;
            buf_addr             <= '0;
            buf_data             <= '0;
        end else begin
            if (invalidate) begin
                buf_valid <= 1'b0;
            end
            if (start && hit) begin
                instruction <= buf_data;
            end
            if (start && !hit) begin
                mem.mem_read_valid   <= 1'b1;
                mem.mem_read_address <= pc;
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
            // The fill is placed last so it wins over a same-edge invalidate.
            if (done) begin
                instruction        <= mem.mem_read_data;
                buf_data           <= mem.mem_read_data;
                buf_addr           <= mem.mem_read_address;
                buf_valid          <= 1'b1;
                mem.mem_read_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a queue-based
// scoreboard checked whenever the fetcher enters F_FETCHED.
module tb_instruction_fetcher;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [2:0]  simd_state;
    logic [7:0]  pc;
    logic        invalidate;
    logic [2:0]  fetcher_state;
    logic [31:0] instruction;
    logic [15:0] miss_count;

    instruction_fetcher_if #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .INSTRUCTION_WIDTH(32)
    ) mem_bus ();

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .INSTRUCTION_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .simd_state(simd_state),
        .pc(pc),
        .invalidate(invalidate),
        .mem(mem_bus.master),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .miss_count(miss_count)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] misses;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [2:0]  prev_state;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] instr, input logic [15:0] misses);
        exp_t e;
        e.instr  = instr;
        e.misses = misses;
        sb_q.push_back(e);
    endtask

    initial prev_state = 3'd0;

    always @(negedge clk) begin
        if (rst && fetcher_state == 3'd2 && prev_state != 3'd2) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got fetch of %h expected none",
                         instruction);
            end else begin
                mon_e = sb_q.pop_front();
                check("mon_instr", instruction, mon_e.instr);
                check("mon_miss", {16'd0, miss_count}, {16'd0, mon_e.misses});
            end
        end
        prev_state = fetcher_state;
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        enable     = 1'b0;
        simd_state = 3'd0;
        pc         = 8'h00;
        invalidate = 1'b0;
        mem_bus.mem_read_ready = 1'b0;
        mem_bus.mem_read_data  = 32'h0;
        tick();
        tick();
        check("rst_state", {29'd0, fetcher_state}, 32'd0);
        check("rst_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        check("rst_addr", {24'd0, mem_bus.mem_read_address}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_miss", {16'd0, miss_count}, 32'd0);
        rst = 1'b1;
        tick();

        // miss at 0x05 with three wait cycles
        push(32'hDEADBEEF, 16'd1);
        enable     = 1'b1;
        pc         = 8'h05;
        simd_state = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("req_valid", {31'd0, mem_bus.mem_read_valid}, 32'd1);
            check("req_addr", {24'd0, mem_bus.mem_read_address}, 32'h05);
            check("req_state", {29'd0, fetcher_state}, 32'd1);
        end
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'hDEADBEEF;
        tick();
        mem_bus.mem_read_ready = 1'b0;
        check("done_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        simd_state = 3'd2;
        tick();
        check("decode_state", {29'd0, fetcher_state}, 32'd0);
        check("decode_instr", instruction, 32'hDEADBEEF);

        // hit on the same PC
        push(32'hDEADBEEF, 16'd1);
        mem_bus.mem_read_data = 32'h0;
        simd_state = 3'd1;
        tick();
        check("hit_state", {29'd0, fetcher_state}, 32'd2);
        check("hit_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        simd_state = 3'd2;
        tick();

        // invalidate at fetch start forces a miss
        push(32'h12345678, 16'd2);
        simd_state = 3'd1;
        invalidate = 1'b1;
        tick();
        check("inv_state", {29'd0, fetcher_state}, 32'd1);
        check("inv_miss", {16'd0, miss_count}, 32'd2);
        invalidate = 1'b0;
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'h12345678;
        tick();
        mem_bus.mem_read_ready = 1'b0;
        simd_state = 3'd2;
        tick();

        // enable low blocks fetch start
        enable     = 1'b0;
        simd_state = 3'd1;
        pc         = 8'h20;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("en_state", {29'd0, fetcher_state}, 32'd0);
            check("en_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        end
        push(32'hCAFEF00D, 16'd3);
        enable = 1'b1;
        tick();
        check("en_start", {29'd0, fetcher_state}, 32'd1);
        check("en_addr", {24'd0, mem_bus.mem_read_address}, 32'h20);
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'hCAFEF00D;
        tick();
        mem_bus.mem_read_ready = 1'b0;
        simd_state = 3'd2;
        tick();

        // stray ready while idle
        simd_state = 3'd0;
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'hBAD0BAD0;
        tick();
        check("stray_state", {29'd0, fetcher_state}, 32'd0);
        check("stray_instr", instruction, 32'hCAFEF00D);
        check("stray_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        mem_bus.mem_read_ready = 1'b0;

        // PC 0xFF, invalidate coinciding with completion keeps the fill
        push(32'hA5A50FF0, 16'd4);
        pc         = 8'hFF;
        simd_state = 3'd1;
        tick();
        check("ff_state", {29'd0, fetcher_state}, 32'd1);
        check("ff_addr", {24'd0, mem_bus.mem_read_address}, 32'hFF);
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'hA5A50FF0;
        invalidate = 1'b1;
        tick();
        mem_bus.mem_read_ready = 1'b0;
        invalidate = 1'b0;
        simd_state = 3'd2;
        tick();
        push(32'hA5A50FF0, 16'd4);
        simd_state = 3'd1;
        tick();
        check("ff_hit_state", {29'd0, fetcher_state}, 32'd2);
        check("ff_hit_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        simd_state = 3'd2;
        tick();

        // async reset mid-request
        pc         = 8'h10;
        simd_state = 3'd1;
        tick();
        check("mid_state", {29'd0, fetcher_state}, 32'd1);
        check("mid_valid", {31'd0, mem_bus.mem_read_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, mem_bus.mem_read_valid}, 32'd0);
        check("arst_state", {29'd0, fetcher_state}, 32'd0);
        check("arst_miss", {16'd0, miss_count}, 32'd0);
        tick();
        rst        = 1'b1;
        simd_state = 3'd0;
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'h00000BAD;
        tick();
        check("late_instr", instruction, 32'd0);
        check("late_state", {29'd0, fetcher_state}, 32'd0);
        mem_bus.mem_read_ready = 1'b0;
        push(32'h11223344, 16'd1);
        pc         = 8'h05;
        simd_state = 3'd1;
        tick();
        check("post_rst_miss", {29'd0, fetcher_state}, 32'd1);
        check("post_rst_valid", {31'd0, mem_bus.mem_read_valid}, 32'd1);
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 32'h11223344;
        tick();
        mem_bus.mem_read_ready = 1'b0;
        simd_state = 3'd2;
        tick();
        simd_state = 3'd0;
        tick();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
